// File: rtl/alu_share_arbiter.sv
// Round-robin share of one registered-latency ALU between two requesters.
// One operation in flight; saturating count of errored results.
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_LATENCY = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_control,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic [3:0]            rsp0_flags,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_control,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [3:0]            rsp1_flags,
  output logic [DATA_WIDTH-1:0] alu_input_a,
  output logic [DATA_WIDTH-1:0] alu_input_b,
  output logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_cout,
  input  logic                  alu_err_overflow,
  input  logic                  alu_err_invalid_control,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state, next_state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             grant0, grant1;
  logic             accept;
  logic             capture;
  logic             rsp_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)   next_state = EXEC;
      EXEC:    if (capture)  next_state = RESP;
      RESP:    if (rsp_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rr_ptr only breaks ties; a lone valid always wins.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !rr_ptr);
    grant1     = req1_valid && (!req0_valid ||  rr_ptr);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    capture    = (state == EXEC) && (cnt == '0);
    rsp_done   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      alu_input_a <= '0;
      alu_input_b <= '0;
      alu_control <= 4'h0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= 4'h0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= 4'h0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        alu_input_a <= req1_ready ? req1_a       : req0_a;
        alu_input_b <= req1_ready ? req1_b       : req0_b;
        alu_control <= req1_ready ? req1_control : req0_control;
        owner       <= req1_ready;
        rr_ptr      <= ~req1_ready;
        cnt         <= CNT_W'(ALU_LATENCY);
      end
      if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (capture) begin
        if (owner) begin
          rsp1_valid  <= 1'b1;
          rsp1_result <= alu_result;
          rsp1_flags  <= {alu_err_invalid_control, alu_err_overflow, alu_cout, alu_zero};
        end else begin
          rsp0_valid  <= 1'b1;
          rsp0_result <= alu_result;
          rsp0_flags  <= {alu_err_invalid_control, alu_err_overflow, alu_cout, alu_zero};
        end
        if ((alu_err_overflow || alu_err_invalid_control) && err_count != '1)
          err_count <= err_count + 1'b1;
      end
      if (rsp_done) begin
        if (owner) rsp1_valid <= 1'b0;
        else       rsp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: ALU model behind the DUT, per-requester
// expected queues filled at issue, and a negedge monitor holding an abstract occupancy model.
module tb_alu_share_arbiter;

  localparam int LAT     = 1;
  localparam int ECW     = 8;
  localparam int ERR_MAX = (1 << ECW) - 1;
  localparam int LAT2    = 3;
  localparam int ECW2    = 3;

  logic        clock, reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [3:0]  req_ctl [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result [2];
  logic [3:0]  rsp_flags [2];
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_c;
  logic        busy;
  logic [ECW-1:0] err_count;
  logic [35:0] pipe [LAT];

  int compared = 0;
  int mismatched = 0;
  int rsp_mode = 0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];

  alu_share_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(LAT), .ERR_CNT_W(ECW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_a(req_a[0]),
    .req0_b(req_b[0]), .req0_control(req_ctl[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rsp_result[0]), .rsp0_flags(rsp_flags[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_a(req_a[1]),
    .req1_b(req_b[1]), .req1_control(req_ctl[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rsp_result[1]), .rsp1_flags(rsp_flags[1]),
    .alu_input_a(alu_a), .alu_input_b(alu_b), .alu_control(alu_c),
    .alu_result(alu_res), .alu_zero(pipe[LAT-1][32]), .alu_cout(pipe[LAT-1][33]),
    .alu_err_overflow(pipe[LAT-1][34]), .alu_err_invalid_control(pipe[LAT-1][35]),
    .busy(busy), .err_count(err_count)
  );

  // Second build: longer ALU latency, narrow error counter.
  logic        d2_valid, d2_ready, d2_rsp_valid, d2_rsp_ready;
  logic [31:0] d2_a, d2_b, d2_result;
  logic [3:0]  d2_ctl, d2_flags;
  logic        d2_r1_ready, d2_rsp1_valid;
  logic [31:0] d2_rsp1_result;
  logic [3:0]  d2_rsp1_flags;
  logic [31:0] d2_alu_a, d2_alu_b;
  logic [3:0]  d2_alu_c;
  logic        d2_busy;
  logic [ECW2-1:0] d2_err;
  logic [35:0] pipe2 [LAT2];

  alu_share_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(LAT2), .ERR_CNT_W(ECW2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(d2_valid), .req0_ready(d2_ready), .req0_a(d2_a), .req0_b(d2_b),
    .req0_control(d2_ctl), .rsp0_valid(d2_rsp_valid), .rsp0_ready(d2_rsp_ready),
    .rsp0_result(d2_result), .rsp0_flags(d2_flags),
    .req1_valid(1'b0), .req1_ready(d2_r1_ready), .req1_a(32'h0), .req1_b(32'h0),
    .req1_control(4'h0), .rsp1_valid(d2_rsp1_valid), .rsp1_ready(1'b1),
    .rsp1_result(d2_rsp1_result), .rsp1_flags(d2_rsp1_flags),
    .alu_input_a(d2_alu_a), .alu_input_b(d2_alu_b), .alu_control(d2_alu_c),
    .alu_result(pipe2[LAT2-1][31:0]), .alu_zero(pipe2[LAT2-1][32]),
    .alu_cout(pipe2[LAT2-1][33]), .alu_err_overflow(pipe2[LAT2-1][34]),
    .alu_err_invalid_control(pipe2[LAT2-1][35]),
    .busy(d2_busy), .err_count(d2_err)
  );

  // Reference ALU: returns {invalid, overflow, cout, zero, result}.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov, inv;
    r = 32'h0; co = 1'b0; ov = 1'b0; inv = 1'b0; s = 33'h0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h3: r = a ^ b;
      4'h6: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r = b << a[4:0];
      4'hC: r = ~(a | b);
      default: inv = 1'b1;
    endcase
    return {inv, ov, co, (r == 32'h0), r};
  endfunction

  always @(posedge clock) begin
    pipe[0] <= alu_ref(alu_a, alu_b, alu_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    pipe2[0] <= alu_ref(d2_alu_a, d2_alu_b, d2_alu_c);
    for (int i = 1; i < LAT2; i++) pipe2[i] <= pipe2[i-1];
  end
  assign alu_res = pipe[LAT-1][31:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++)
        case (rsp_mode)
          0: rsp_ready[i] = 1'b1;
          1: rsp_ready[i] = ($urandom_range(0, 2) != 0);
          default: rsp_ready[i] = 1'b0;
        endcase
    end
  end

  // Abstract model: one op outstanding at a time, response due LAT+1 edges after accept,
  // ties go to whichever requester did not win last.
  bit outstanding, pend_acc, pend_rel, owner, pend_owner, prefer;
  int age, err_exp;
  logic [35:0] front;
  bit exp_rdy0, exp_rdy1, rv_exp;

  always @(negedge clock) begin
    if (!reset_n) begin
      outstanding = 0; pend_acc = 0; pend_rel = 0; prefer = 0; age = 0; err_exp = 0;
    end else begin
      if (outstanding) age++;
      if (pend_rel) begin outstanding = 0; pend_rel = 0; end
      if (pend_acc) begin outstanding = 1; owner = pend_owner; age = 0; pend_acc = 0; end
      exp_rdy0 = !outstanding && req_valid[0] && (!req_valid[1] || !prefer);
      exp_rdy1 = !outstanding && req_valid[1] && (!req_valid[0] ||  prefer);
      chk("req0_ready", req_ready[0], exp_rdy0);
      chk("req1_ready", req_ready[1], exp_rdy1);
      chk("busy", busy, outstanding);
      rv_exp = outstanding && (age >= LAT + 1);
      chk("rsp0_valid", rsp_valid[0], rv_exp && !owner);
      chk("rsp1_valid", rsp_valid[1], rv_exp && owner);
      if (rv_exp) begin
        if ((owner ? q1.size() : q0.size()) == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          front = owner ? q1[0] : q0[0];
          if (age == LAT + 1 && (front[35] || front[34]) && err_exp < ERR_MAX) err_exp++;
          chk("rsp_result", rsp_result[owner], front[31:0]);
          chk("rsp_flags", rsp_flags[owner], front[35:32]);
          if (rsp_ready[owner]) begin
            if (owner) void'(q1.pop_front()); else void'(q0.pop_front());
            pend_rel = 1;
          end
        end
      end
      chk("err_count", err_count, err_exp);
      if (exp_rdy0 || exp_rdy1) begin
        pend_acc = 1; pend_owner = exp_rdy1; prefer = !exp_rdy1;
      end
    end
  end

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c);
    bit ok;
    ok = 0;
    if (id == 0) q0.push_back(alu_ref(a, b, c)); else q1.push_back(alu_ref(a, b, c));
    req_a[id] = a; req_b[id] = b; req_ctl[id] = c; req_valid[id] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (req_ready[id]) begin ok = 1; break; end
    end
    @(posedge clock);
    #1;
    req_valid[id] = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      if (id == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
  endtask

  task automatic rand_issue(input int id);
    logic [3:0] ctl_set [10];
    ctl_set = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'hC, 4'h5, 4'hF};
    issue(id, $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
          ctl_set[$urandom_range(0, 9)]);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (q0.size() == 0 && q1.size() == 0 && !busy) begin done = 1; break; end
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  int lat;
  bit seen;

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_a[i] = '0; req_b[i] = '0; req_ctl[i] = '0;
    end
    d2_valid = 1'b0; d2_a = '0; d2_b = '0; d2_ctl = '0; d2_rsp_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp_valid[0], 0);
    chk("rst_rsp1_valid", rsp_valid[1], 0);
    chk("rst_rsp0_data", {rsp_result[0], rsp_flags[0]}, 0);
    chk("rst_rsp1_data", {rsp_result[1], rsp_flags[1]}, 0);
    chk("rst_alu_ops", {alu_a, alu_b, alu_c}, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_d2_busy", d2_busy, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Tie from reset: requester 0 first, then requester 1.
    fork
      issue(0, 32'd3, 32'd3, 4'h6);
      issue(1, 32'hF0, 32'h0F, 4'h1);
    join
    wait_idle();
    issue(0, 32'd5, 32'd7, 4'h2);
    wait_idle();
    // Sustained load on both sides alternates.
    fork
      for (int k = 0; k < 4; k++) rand_issue(0);
      for (int k = 0; k < 4; k++) rand_issue(1);
    join
    wait_idle();
    issue(1, 32'h7FFF_FFFF, 32'd1, 4'h2);
    issue(1, 32'd9, 32'd4, 4'h5);
    wait_idle();

    // Held response blocks the other requester.
    rsp_mode = 2;
    fork
      issue(0, 32'h1234_5678, 32'h0000_FFFF, 4'h0);
      begin #20; issue(1, 32'd100, 32'd1, 4'h6); end
      begin repeat (14) @(posedge clock); #1 rsp_mode = 0; end
    join
    wait_idle();

    rsp_mode = 1;
    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 rand_issue(0);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 rand_issue(1);
      end
    join
    rsp_mode = 0;
    wait_idle();

    // Reset while the op is executing: dropped, no response afterwards.
    issue(0, 32'd1, 32'd2, 4'h2);
    reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rsp0_valid", rsp_valid[0], 0);
    chk("async_rsp1_valid", rsp_valid[1], 0);
    chk("async_err_count", err_count, 0);
    q0.delete();
    q1.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;

    // Saturation of the error counter.
    for (int k = 0; k < ERR_MAX + 4; k++)
      issue(k % 2, 32'h7FFF_FFFF, 32'd1 + $urandom_range(0, 100), 4'h2);
    wait_idle();
    chk("err_count_saturated", err_count, ERR_MAX);

    // Latency-3 build: response 4 edges after accept, 3-bit counter saturates.
    for (int i = 0; i < (1 << ECW2) + 3; i++) begin
      d2_a = 32'h7FFF_FFFF; d2_b = 32'd1; d2_ctl = 4'h2; d2_valid = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (d2_ready) begin seen = 1; break; end
      end
      if (!seen) chk("d2_accept_timeout", 0, 1);
      @(posedge clock);
      #1 d2_valid = 1'b0;
      lat = 0; seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (d2_rsp_valid) begin seen = 1; break; end
        lat++;
      end
      chk("d2_rsp_seen", seen, 1);
      chk("d2_latency", lat, LAT2 + 1);
      chk("d2_result", d2_result, 32'h8000_0000);
      chk("d2_flags", d2_flags, 4'b0100);
      chk("d2_err_count", d2_err, (i + 1 < 7) ? i + 1 : 7);
      @(posedge clock);
      #1;
    end

    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
